// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared states, forwarding selects and constants for the hazard controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MISS_WAIT = 2'd1,
        DRAIN     = 2'd2,
        HALTED    = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_compare.sv
// rtl/hazard_compare.sv - per-operand RAW hit and forwarding select for one ID source register
// Optional FWD_EN: stall only on load-use and produce a forwarding select; otherwise stall on any match.
module hazard_compare
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic       i_uses,
    input  logic [4:0] i_ex_dest,
    input  logic       i_ex_write,
    input  logic       i_ex_load,
    input  logic [4:0] i_mem_dest,
    input  logic       i_mem_write,
    output logic       o_raw_hit,
    output logic [1:0] o_fwd_sel
);

    logic w_live;
    logic w_ex_hit;
    logic w_mem_hit;

    always_comb begin
        w_live    = i_uses && (i_src != REG_ZERO);
        w_ex_hit  = w_live && i_ex_write && (i_src == i_ex_dest);
        w_mem_hit = w_live && i_mem_write && (i_src == i_mem_dest);
    end

`ifdef FWD_EN
    // The EX producer is the youngest write, so its value wins over the older MEM one.
    always_comb begin
        o_raw_hit = w_ex_hit && i_ex_load;
        if (w_ex_hit) begin
            o_fwd_sel = FWD_EXMEM;
        end else if (w_mem_hit) begin
            o_fwd_sel = FWD_MEMWB;
        end else begin
            o_fwd_sel = FWD_RF;
        end
    end
`else
    logic w_unused_load;

    assign w_unused_load = i_ex_load;
    assign o_raw_hit     = w_ex_hit || w_mem_hit;
    assign o_fwd_sel     = FWD_RF;
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/halt sequencer for the 5-stage pipeline
// Optional FWD_EN: operand forwarding with load-use-only stalls (see hazard_compare).
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
)
(
    input  logic             clk,
    input  logic             rst_b,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_dest,
    input  logic             ex_reg_write,
    input  logic             ex_is_load,
    input  logic [4:0]       mem_dest,
    input  logic             mem_reg_write,
    input  logic             ex_redirect,
    input  logic             cache_miss,
    input  logic             cache_ready,
    input  logic             ex_halted,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    ctrl_state_e      r_state;
    ctrl_state_e      w_next;
    logic [DW-1:0]    r_drain_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic             w_hit_a;
    logic             w_hit_b;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic             w_raw;
    logic             w_drain_done;

    hazard_compare u_cmp_rs (
        .i_src       (id_rs),
        .i_uses      (id_uses_rs),
        .i_ex_dest   (ex_dest),
        .i_ex_write  (ex_reg_write),
        .i_ex_load   (ex_is_load),
        .i_mem_dest  (mem_dest),
        .i_mem_write (mem_reg_write),
        .o_raw_hit   (w_hit_a),
        .o_fwd_sel   (w_fwd_a)
    );

    hazard_compare u_cmp_rt (
        .i_src       (id_rt),
        .i_uses      (id_uses_rt),
        .i_ex_dest   (ex_dest),
        .i_ex_write  (ex_reg_write),
        .i_ex_load   (ex_is_load),
        .i_mem_dest  (mem_dest),
        .i_mem_write (mem_reg_write),
        .o_raw_hit   (w_hit_b),
        .o_fwd_sel   (w_fwd_b)
    );

    assign w_raw        = w_hit_a || w_hit_b;
    assign w_drain_done = (r_drain_cnt == DW'(DRAIN_CYCLES - 1));

    // Event priority in RUN: halt, then miss, then redirect, then RAW bubble.
    always_comb begin
        w_next      = r_state;
        pc_hold     = 1'b0;
        if_id_hold  = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_freeze = 1'b0;
        halted      = 1'b0;
        if (!rst_b) begin
            case (r_state)
                RUN: begin
                    if (ex_halted) begin
                        w_next = DRAIN;
                    end else if (cache_miss) begin
                        w_next      = MISS_WAIT;
                        pc_hold     = 1'b1;
                        if_id_hold  = 1'b1;
                        pipe_freeze = 1'b1;
                    end else if (ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (w_raw) begin
                        pc_hold     = 1'b1;
                        if_id_hold  = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                MISS_WAIT: begin
                    pc_hold     = 1'b1;
                    if_id_hold  = 1'b1;
                    pipe_freeze = 1'b1;
                    if (cache_ready) begin
                        w_next = RUN;
                    end
                end
                DRAIN: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (cache_miss) begin
                        pc_hold     = 1'b1;
                        if_id_hold  = 1'b1;
                        pipe_freeze = 1'b1;
                    end else if (w_drain_done) begin
                        w_next = HALTED;
                    end
                end
                HALTED: begin
                    pc_hold = 1'b1;
                    halted  = 1'b1;
                end
                default: w_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Drain progress pauses while the MEM stage is stuck on a miss.
    always_ff @(posedge clk) begin
        if (rst_b || r_state != DRAIN) begin
            r_drain_cnt <= '0;
        end else if (!cache_miss) begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_stall_cnt <= '0;
        end else if (pc_hold && r_state != HALTED && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (pipe_freeze) begin
            r_fwd_a <= r_fwd_a;
            r_fwd_b <= r_fwd_b;
        end else if (id_ex_flush) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            r_fwd_a <= w_fwd_a;
            r_fwd_b <= w_fwd_b;
        end
    end

    assign fwd_a_sel   = r_fwd_a;
    assign fwd_b_sel   = r_fwd_b;
    assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard testbench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 32;

`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {pc_hold, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze, halted}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] BUB  = 6'b110100;
    localparam logic [5:0] FLSH = 6'b001100;
    localparam logic [5:0] FRZ  = 6'b110010;
    localparam logic [5:0] DRNM = 6'b111110;
    localparam logic [5:0] HLT  = 6'b100001;

    // {rst, halt, ready, miss, redirect}
    localparam logic [4:0] EV_NONE  = 5'b00000;
    localparam logic [4:0] EV_RST   = 5'b10000;
    localparam logic [4:0] EV_HALT  = 5'b01000;
    localparam logic [4:0] EV_RDY   = 5'b00100;
    localparam logic [4:0] EV_MISS  = 5'b00010;
    localparam logic [4:0] EV_REDIR = 5'b00001;

    localparam logic [4:0] Z  = 5'd0;
    localparam logic [4:0] R4 = 5'd4;
    localparam logic [4:0] R5 = 5'd5;
    localparam logic [4:0] R6 = 5'd6;
    localparam logic [4:0] R3 = 5'd3;
    localparam logic [4:0] T0 = 5'd8;
    localparam logic [4:0] T1 = 5'd9;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] exd;
        logic       exw;
        logic       exl;
        logic [4:0] memd;
        logic       memw;
        logic [4:0] ev;
        logic [5:0] eo;
        logic [3:0] ef;
    } stim_t;

    typedef struct {
        logic [9:0]       o;
        logic [CNT_W-1:0] sc;
    } exp_t;

    logic             clk;
    logic             rst_b;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [4:0]       ex_dest;
    logic             ex_reg_write;
    logic             ex_is_load;
    logic [4:0]       mem_dest;
    logic             mem_reg_write;
    logic             ex_redirect;
    logic             cache_miss;
    logic             cache_ready;
    logic             ex_halted;
    logic             pc_hold;
    logic             if_id_hold;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_freeze;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             halted;
    logic [CNT_W-1:0] stall_count;
    logic [9:0]       obs;

    exp_t             sb[$];
    logic [CNT_W-1:0] exp_sc = '0;
    int               checks = 0;
    int               failures = 0;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .ex_dest       (ex_dest),
        .ex_reg_write  (ex_reg_write),
        .ex_is_load    (ex_is_load),
        .mem_dest      (mem_dest),
        .mem_reg_write (mem_reg_write),
        .ex_redirect   (ex_redirect),
        .cache_miss    (cache_miss),
        .cache_ready   (cache_ready),
        .ex_halted     (ex_halted),
        .pc_hold       (pc_hold),
        .if_id_hold    (if_id_hold),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .pipe_freeze   (pipe_freeze),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .halted        (halted),
        .stall_count   (stall_count)
    );

    assign obs = {pc_hold, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze, halted, fwd_a_sel, fwd_b_sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                 input logic urt, input logic [4:0] exd, input logic exw,
                                 input logic exl, input logic [4:0] memd, input logic memw,
                                 input logic [4:0] ev, input logic [5:0] eo, input logic [3:0] ef);
        stim_t s;
        s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt;
        s.exd = exd; s.exw = exw; s.exl = exl;
        s.memd = memd; s.memw = memw; s.ev = ev; s.eo = eo; s.ef = ef;
        return s;
    endfunction

    function automatic stim_t idle(input logic [4:0] ev, input logic [5:0] eo, input logic [3:0] ef);
        return mk(Z, Z, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0, ev, eo, ef);
    endfunction

    // Drives one cycle of inputs and queues what the outputs must be in that cycle.
    task automatic apply(input stim_t s);
        exp_t e;
        id_rs = s.rs; id_rt = s.rt; id_uses_rs = s.urs; id_uses_rt = s.urt;
        ex_dest = s.exd; ex_reg_write = s.exw; ex_is_load = s.exl;
        mem_dest = s.memd; mem_reg_write = s.memw;
        rst_b = s.ev[4]; ex_halted = s.ev[3]; cache_ready = s.ev[2];
        cache_miss = s.ev[1]; ex_redirect = s.ev[0];
        e.o  = {s.eo, s.ef};
        e.sc = exp_sc;
        sb.push_back(e);
        if (s.ev[4]) begin
            exp_sc = '0;
        end else if (s.eo[5] && !s.eo[0] && exp_sc != '1) begin
            exp_sc = exp_sc + 1'b1;
        end
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(T0, Z, 1'b1, 1'b0, T0, 1'b1, 1'b1, Z, 1'b0, EV_RST | EV_MISS | EV_REDIR, NONE, 4'b0000));
        st.push_back(idle(EV_NONE, NONE, 4'b0000));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e.o || stall_count !== e.sc) begin
                failures++;
                $display("FAIL reset step %0d: outputs=%b stall_count=%0d, required outputs=%b stall_count=%0d", i, obs, stall_count, e.o, e.sc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(T0, Z, 1'b1, 1'b0, T0, 1'b1, 1'b1, Z, 1'b0, EV_NONE, BUB, 4'b0000));
        st.push_back(mk(T0, Z, 1'b1, 1'b0, Z, 1'b0, 1'b0, T0, 1'b1, EV_NONE, FWD ? NONE : BUB, 4'b0000));
        st.push_back(mk(T0, Z, 1'b1, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0, EV_NONE, NONE, FWD ? 4'b1000 : 4'b0000));
        st.push_back(idle(EV_NONE, NONE, 4'b0000));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e.o || stall_count !== e.sc) begin
                failures++;
                $display("FAIL load_use step %0d: outputs=%b stall_count=%0d, required outputs=%b stall_count=%0d", i, obs, stall_count, e.o, e.sc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_operands();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(Z, Z, 1'b1, 1'b1, Z, 1'b1, 1'b0, Z, 1'b1, EV_NONE, NONE, 4'b0000));
        st.push_back(idle(EV_NONE, NONE, 4'b0000));
        st.push_back(mk(T0, R3, 1'b0, 1'b0, T0, 1'b1, 1'b1, R3, 1'b1, EV_NONE, NONE, 4'b0000));
        st.push_back(mk(R4, T1, 1'b0, 1'b1, R4, 1'b1, 1'b0, T1, 1'b1, EV_NONE, FWD ? NONE : BUB, 4'b0000));
        st.push_back(idle(EV_NONE, NONE, FWD ? 4'b0010 : 4'b0000));
        st.push_back(mk(R5, Z, 1'b1, 1'b0, R5, 1'b1, 1'b0, R5, 1'b1, EV_NONE, FWD ? NONE : BUB, 4'b0000));
        st.push_back(idle(EV_NONE, NONE, FWD ? 4'b0100 : 4'b0000));
        st.push_back(mk(R6, Z, 1'b1, 1'b0, R6, 1'b0, 1'b1, Z, 1'b0, EV_NONE, NONE, 4'b0000));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e.o || stall_count !== e.sc) begin
                failures++;
                $display("FAIL operands step %0d: outputs=%b stall_count=%0d, required outputs=%b stall_count=%0d", i, obs, stall_count, e.o, e.sc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_miss();
        stim_t st[$];
        exp_t  e;
        for (int c = 0; c < 10; c++) begin
            st.push_back(mk(T0, Z, 1'b1, 1'b0, T0, 1'b1, 1'b1, Z, 1'b0, EV_MISS | EV_REDIR, FRZ, 4'b0000));
        end
        st.push_back(mk(T0, Z, 1'b1, 1'b0, T0, 1'b1, 1'b1, Z, 1'b0, EV_MISS | EV_RDY | EV_REDIR, FRZ, 4'b0000));
        st.push_back(idle(EV_REDIR, FLSH, 4'b0000));
        st.push_back(idle(EV_NONE, NONE, 4'b0000));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e.o || stall_count !== e.sc) begin
                failures++;
                $display("FAIL miss step %0d: outputs=%b stall_count=%0d, required outputs=%b stall_count=%0d", i, obs, stall_count, e.o, e.sc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_redirect_hazard();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(T0, Z, 1'b1, 1'b0, T0, 1'b1, 1'b1, Z, 1'b0, EV_REDIR, FLSH, 4'b0000));
        st.push_back(idle(EV_NONE, NONE, 4'b0000));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e.o || stall_count !== e.sc) begin
                failures++;
                $display("FAIL redirect_hazard step %0d: outputs=%b stall_count=%0d, required outputs=%b stall_count=%0d", i, obs, stall_count, e.o, e.sc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_halt();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(T0, Z, 1'b1, 1'b0, T0, 1'b1, 1'b1, Z, 1'b0, EV_HALT, NONE, 4'b0000));
        st.push_back(idle(EV_NONE, FLSH, 4'b0000));
        st.push_back(idle(EV_NONE, FLSH, 4'b0000));
        st.push_back(idle(EV_MISS, DRNM, 4'b0000));
        st.push_back(idle(EV_MISS, DRNM, 4'b0000));
        st.push_back(idle(EV_NONE, FLSH, 4'b0000));
        st.push_back(idle(EV_NONE, HLT, 4'b0000));
        st.push_back(idle(EV_REDIR | EV_MISS, HLT, 4'b0000));
        st.push_back(idle(EV_HALT, HLT, 4'b0000));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e.o || stall_count !== e.sc) begin
                failures++;
                $display("FAIL halt step %0d: outputs=%b stall_count=%0d, required outputs=%b stall_count=%0d", i, obs, stall_count, e.o, e.sc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_miss();
        stim_t st[$];
        exp_t  e;
        st.push_back(idle(EV_RST, NONE, 4'b0000));
        st.push_back(idle(EV_MISS, FRZ, 4'b0000));
        st.push_back(idle(EV_MISS, FRZ, 4'b0000));
        st.push_back(idle(EV_RST | EV_MISS, NONE, 4'b0000));
        st.push_back(idle(EV_NONE, NONE, 4'b0000));
        st.push_back(idle(EV_REDIR, FLSH, 4'b0000));
        st.push_back(idle(EV_NONE, NONE, 4'b0000));
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e.o || stall_count !== e.sc) begin
                failures++;
                $display("FAIL reset_miss step %0d: outputs=%b stall_count=%0d, required outputs=%b stall_count=%0d", i, obs, stall_count, e.o, e.sc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        id_rs = Z; id_rt = Z; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_dest = Z; ex_reg_write = 1'b0; ex_is_load = 1'b0;
        mem_dest = Z; mem_reg_write = 1'b0;
        ex_redirect = 1'b0; cache_miss = 1'b0; cache_ready = 1'b0; ex_halted = 1'b0;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_operands();
        test_miss();
        test_redirect_hazard();
        test_halt();
        test_reset_miss();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
